// File: rtl/l2_pkg.sv
// Shared definitions for the L2 responder: line geometry and read FSM encoding.
package l2_pkg;

  localparam int unsigned LINE_W   = 27;
  localparam int unsigned LINE_OFF = 5;

  typedef enum logic [2:0] {
    R_IDLE,
    R_HAZARD,
    R_WAIT,
    R_ACK,
    R_COOL
  } rd_state_e;

  // Line address of a byte address.
  function automatic logic [LINE_W-1:0] addr2line(input logic [31:0] a);
    return a[31:LINE_OFF];
  endfunction

endpackage

// File: rtl/l2_responder_if.sv
// Request/response and memory-drain signals between L1 controller, L2 responder and memory.
interface l2_responder_if;
  import l2_pkg::*;

  logic              read_l2;
  logic              write_l2;
  logic [31:0]       addr;
  logic              l2_ack;
  logic              mem_wr_valid;
  logic [LINE_W-1:0] mem_wr_line;
  logic              mem_wr_ready;
  logic              wb_full;
  logic              wb_empty;
  logic              wb_err;

  // Requester / memory side.
  modport master (
    output read_l2, write_l2, addr, mem_wr_ready,
    input  l2_ack, mem_wr_valid, mem_wr_line, wb_full, wb_empty, wb_err
  );

  // Responder side.
  modport slave (
    input  read_l2, write_l2, addr, mem_wr_ready,
    output l2_ack, mem_wr_valid, mem_wr_line, wb_full, wb_empty, wb_err
  );

endinterface

// File: rtl/line_fifo.sv
// Circular FIFO of line addresses; exposes every slot for hazard comparison.
module line_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [Width-1:0]       head_o,
  output logic [Depth-1:0]       ent_valid_o,
  output logic [Depth*Width-1:0] ent_line_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Depth-1:0] vld_q, vld_d;
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);

  // Pointer/count update; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    mem_d   = mem_q;
    vld_d   = vld_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    // Pop before push so a full-and-popping push into the same slot stays valid.
    if (do_pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PtrW'(1);
    end
    if (do_push) begin
      mem_d[wr_q] = push_data_i;
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + PtrW'(1);
    end
    cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Head and flattened per-slot views.
  always_comb begin
    head_o      = empty_o ? '0 : mem_q[rd_q];
    ent_valid_o = vld_q;
    ent_line_o  = '0;
    for (int i = 0; i < Depth; i++) ent_line_o[i*Width +: Width] = mem_q[i];
  end

endmodule

// File: rtl/l2_responder.sv
// L2 responder: captures write-buffer bursts into a line FIFO and answers fills
// after a fixed latency, holding off reads that hit a buffered or in-flight line.
module l2_responder
  import l2_pkg::*;
#(
  parameter int unsigned READ_LAT   = 4,
  parameter int unsigned WB_BEATS   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  l2_responder_if.slave  bus
);

  localparam int unsigned BeatW = $clog2(WB_BEATS);
  localparam int unsigned LatW  = $clog2(READ_LAT);

  logic [BeatW-1:0]  beat_q, beat_d;
  logic [LINE_W-1:0] cap_line_q, cap_line_d;
  logic              wb_err_q, wb_err_d;
  rd_state_e         state_q, state_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [LINE_W-1:0] rd_line_q, rd_line_d;
  logic              l2_ack_q, l2_ack_d;

  logic                         push, short_burst;
  logic                         fifo_full, fifo_empty, fifo_pop;
  logic [LINE_W-1:0]            fifo_head;
  logic [FIFO_DEPTH-1:0]        ent_valid;
  logic [FIFO_DEPTH*LINE_W-1:0] ent_line;
  logic [LINE_W-1:0]            cmp_line;
  logic                         hazard;

  assign fifo_pop = !fifo_empty && bus.mem_wr_ready;

  line_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (LINE_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (cap_line_q),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .ent_valid_o (ent_valid),
    .ent_line_o  (ent_line)
  );

  // Burst capture: latch line on first beat, push on last, flag truncated bursts.
  always_comb begin
    beat_d      = beat_q;
    cap_line_d  = cap_line_q;
    push        = 1'b0;
    short_burst = 1'b0;
    if (bus.write_l2) begin
      if (beat_q == '0) cap_line_d = addr2line(bus.addr);
      if (beat_q == BeatW'(WB_BEATS - 1)) begin
        push   = 1'b1;
        beat_d = '0;
      end else begin
        beat_d = beat_q + BeatW'(1);
      end
    end else if (beat_q != '0) begin
      beat_d      = '0;
      short_burst = 1'b1;
    end
    wb_err_d = wb_err_q | short_burst | (push && fifo_full && !fifo_pop);
  end

  // Hazard: requested line matches a buffered entry or the burst being captured.
  always_comb begin
    hazard   = 1'b0;
    cmp_line = (state_q == R_IDLE) ? addr2line(bus.addr) : rd_line_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && (ent_line[i*LINE_W +: LINE_W] == cmp_line)) hazard = 1'b1;
    end
    if ((beat_q != '0) && (cap_line_q == cmp_line)) hazard = 1'b1;
    if (bus.write_l2 && (beat_q == '0) && (addr2line(bus.addr) == cmp_line)) hazard = 1'b1;
  end

  // Read FSM next state; ack is registered from the next state.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    rd_line_d = rd_line_q;
    unique case (state_q)
      R_IDLE: begin
        if (bus.read_l2) begin
          rd_line_d = addr2line(bus.addr);
          if (hazard) begin
            state_d = R_HAZARD;
          end else begin
            state_d = R_WAIT;
            lat_d   = LatW'(READ_LAT - 1);
          end
        end
      end
      R_HAZARD: begin
        if (!bus.read_l2) begin
          state_d = R_IDLE;
        end else if (!hazard) begin
          state_d = R_WAIT;
          lat_d   = LatW'(READ_LAT - 1);
        end
      end
      R_WAIT: begin
        if (!bus.read_l2)     state_d = R_IDLE;
        else if (lat_q == '0) state_d = R_ACK;
        else                  lat_d   = lat_q - LatW'(1);
      end
      R_ACK:   state_d = R_COOL;
      // Requester drops read_l2 a cycle late; don't restart on it.
      R_COOL:  state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
    l2_ack_d = (state_d == R_ACK);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q     <= '0;
      cap_line_q <= '0;
      wb_err_q   <= 1'b0;
      state_q    <= R_IDLE;
      lat_q      <= '0;
      rd_line_q  <= '0;
      l2_ack_q   <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      cap_line_q <= cap_line_d;
      wb_err_q   <= wb_err_d;
      state_q    <= state_d;
      lat_q      <= lat_d;
      rd_line_q  <= rd_line_d;
      l2_ack_q   <= l2_ack_d;
    end
  end

  assign bus.l2_ack       = l2_ack_q;
  assign bus.mem_wr_valid = !fifo_empty;
  assign bus.mem_wr_line  = fifo_head;
  assign bus.wb_full      = fifo_full;
  assign bus.wb_empty     = fifo_empty && (beat_q == '0);
  assign bus.wb_err       = wb_err_q;

endmodule

// File: tb/tb_l2_responder.sv
// Scoreboard bench for l2_responder: stimulus queues expected acks/pops with their
// cycle numbers, a monitor compares whatever the DUT presents.
module tb_l2_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int unsigned ack_q[$];
  int unsigned pop_cyc_q[$];
  logic [26:0] pop_line_q[$];

  l2_responder_if bus ();

  l2_responder #(
    .READ_LAT   (4),
    .WB_BEATS   (8),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_l2_ack"},   32'(bus.l2_ack), 32'd0);
    chk({tag, "_mem_wr_valid"}, 32'(bus.mem_wr_valid), 32'd0);
    chk({tag, "_mem_wr_line"},  32'(bus.mem_wr_line), 32'd0);
    chk({tag, "_wb_full"},  32'(bus.wb_full), 32'd0);
    chk({tag, "_wb_empty"}, 32'(bus.wb_empty), 32'd1);
    chk({tag, "_wb_err"},   32'(bus.wb_err), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Holds write_l2 for n cycles starting at the current negedge.
  task automatic burst(input logic [31:0] a, input int n);
    bus.write_l2 = 1'b1;
    bus.addr     = a;
    repeat (n) tick();
    bus.write_l2 = 1'b0;
  endtask

  // Monitor: sample after inputs settle, well before the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (bus.l2_ack) begin
        if (ack_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
        end else begin
          chk("ack_cycle", cyc, ack_q.pop_front());
        end
      end
      if (bus.mem_wr_valid && bus.mem_wr_ready) begin
        if (pop_cyc_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pop: got line %0h at cycle %0d, expected none",
                   bus.mem_wr_line, cyc);
        end else begin
          chk("pop_cycle", cyc, pop_cyc_q.pop_front());
          chk("pop_line", 32'(bus.mem_wr_line), 32'(pop_line_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int unsigned c;
    bus.read_l2      = 1'b0;
    bus.write_l2     = 1'b0;
    bus.addr         = '0;
    bus.mem_wr_ready = 1'b0;
    repeat (2) tick();
    chk_reset_vals("por");
    reset = 1'b0;
    repeat (2) tick();

    // Clean read of line 0x100; held read_l2 after ack must not re-trigger.
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h0000_2000;
    c = cyc;
    ack_q.push_back(c + 5);
    repeat (6) tick();
    bus.read_l2 = 1'b0;
    repeat (4) tick();

    // Burst to 0x2040 -> line 0x102, drained the cycle after push.
    bus.mem_wr_ready = 1'b1;
    c = cyc;
    pop_cyc_q.push_back(c + 8);
    pop_line_q.push_back(27'h102);
    burst(32'h0000_2040, 8);
    chk("burst_head_line", 32'(bus.mem_wr_line), 32'h102);
    chk("burst_not_empty", 32'(bus.wb_empty), 32'd0);
    tick();
    chk("burst_empty_after_pop", 32'(bus.wb_empty), 32'd1);
    repeat (2) tick();

    // Hazard: read of a buffered line waits for the pop, then full latency.
    bus.mem_wr_ready = 1'b0;
    burst(32'h0000_2040, 8);
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h0000_2040;
    repeat (3) tick();
    chk("hazard_entry_held", 32'(bus.mem_wr_valid), 32'd1);
    bus.mem_wr_ready = 1'b1;
    c = cyc;
    pop_cyc_q.push_back(c);
    pop_line_q.push_back(27'h102);
    ack_q.push_back(c + 6);
    repeat (7) tick();
    bus.read_l2 = 1'b0;
    repeat (3) tick();

    // Overflow: five bursts into a depth-4 FIFO with memory stalled.
    do_reset();
    bus.mem_wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      burst(32'((32'h200 + k) << 5), 8);
      if (k == 3) begin
        chk("ovf_full_at_4", 32'(bus.wb_full), 32'd1);
        chk("ovf_no_err_at_4", 32'(bus.wb_err), 32'd0);
      end
      tick();
    end
    chk("ovf_err", 32'(bus.wb_err), 32'd1);
    chk("ovf_still_full", 32'(bus.wb_full), 32'd1);
    bus.mem_wr_ready = 1'b1;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      pop_cyc_q.push_back(c + k);
      pop_line_q.push_back(27'(32'h200 + k));
    end
    repeat (6) tick();
    chk("drain_empty", 32'(bus.wb_empty), 32'd1);
    chk("drain_not_full", 32'(bus.wb_full), 32'd0);

    // Short burst: three beats then drop.
    do_reset();
    burst(32'h0000_5000, 3);
    tick();
    chk("short_err", 32'(bus.wb_err), 32'd1);
    chk("short_empty", 32'(bus.wb_empty), 32'd1);
    chk("short_no_valid", 32'(bus.mem_wr_valid), 32'd0);
    repeat (2) tick();

    // Reset while a read is in R_WAIT and a burst is two beats in.
    do_reset();
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h0000_3000;
    tick();
    bus.write_l2 = 1'b1;
    bus.addr     = 32'h0000_4000;
    repeat (2) tick();
    reset        = 1'b1;
    bus.read_l2  = 1'b0;
    bus.write_l2 = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    chk_reset_vals("rst_next");
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_no_err", 32'(bus.wb_err), 32'd0);
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h0000_3000;
    c = cyc;
    ack_q.push_back(c + 5);
    repeat (6) tick();
    bus.read_l2 = 1'b0;
    repeat (6) tick();

    foreach (ack_q[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_ack: got none, expected ack at cycle %0d", ack_q[i]);
    end
    foreach (pop_cyc_q[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_pop: got none, expected line %0h at cycle %0d",
               pop_line_q[i], pop_cyc_q[i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
# l2_responder

L2-side responder for the L1 data cache controller's `read_l2` / `write_l2` / `l2_ack` interface. It absorbs 8-beat write-buffer bursts into a small line-address FIFO and drains them to memory. It answers line-fill reads with a single-cycle `l2_ack` after a fixed latency. A read never overtakes a buffered write to the same line.

## Interface
Parameters:
- `READ_LAT`, 4: cycles from accepted read to `l2_ack` (≥2).
- `WB_BEATS`, 8: cycles `write_l2` is held per evicted line.
- `FIFO_DEPTH`, 4: buffered line entries (power of two).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `read_l2`  in  1  fill request; level, held until `l2_ack`.
- `write_l2`  in  1  write-buffer burst; level, held `WB_BEATS` cycles.
- `addr`  in  32  byte address; line = `addr[31:5]`.
- `l2_ack`  out  1  one-cycle pulse, fill data available.
- `mem_wr_valid`  out  1  head FIFO entry valid.
- `mem_wr_line`  out  27  head entry line address.
- `mem_wr_ready`  in  1  memory accepts head entry.
- `wb_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `wb_empty`  out  1  FIFO empty and no burst in progress.
- `wb_err`  out  1  sticky: overflow or short burst.

## Operation
- Reset values: `l2_ack`=0, `mem_wr_valid`=0, `mem_wr_line`=0, `wb_full`=0, `wb_empty`=1, `wb_err`=0. Read FSM is in R_IDLE; beat counter is 0.
- Write capture runs independently of the read FSM:
  - The first cycle with `write_l2`=1 and beat count 0 latches `addr[31:5]`.
  - The beat count increments every cycle `write_l2`=1.
  - On beat `WB_BEATS`, the latched line is pushed and the count returns to 0.
  - If `write_l2` drops with count in 1..`WB_BEATS`-1: discard the line, clear the count, set `wb_err`.
- Push while full: entry dropped, `wb_err` set. Exception: a pop in the same cycle frees a slot, so the push is accepted.
- Pop occurs when `mem_wr_valid`&`mem_wr_ready`. A push into an empty FIFO makes `mem_wr_valid` high on the next cycle; no bypass.
- Read FSM states: R_IDLE, R_HAZARD, R_WAIT, R_ACK, R_COOL.
  - R_IDLE: when `read_l2`=1, compute hazard = line matches any valid FIFO entry or the in-progress capture line. Go to R_HAZARD if hazard, else R_WAIT with the counter loaded to `READ_LAT`-1.
  - R_HAZARD: re-evaluate every cycle; go to R_WAIT (counter loaded) once clear.
  - R_WAIT: decrement; at 0 go to R_ACK.
  - R_ACK: `l2_ack`=1 for exactly one cycle; go to R_COOL.
  - R_COOL: ignore `read_l2` for one cycle (the requester deasserts one cycle late); go to R_IDLE.
- `read_l2` dropping in R_HAZARD or R_WAIT aborts to R_IDLE with no ack.
- Simultaneous `read_l2` and `write_l2`: both processes run. The capture line counts as a hazard from its first beat.

## Timing
- `l2_ack` is registered. For `read_l2` sampled at edge 0 with no hazard, `l2_ack` is high in the cycle after edge `READ_LAT`.
- Hazard adds cycles until the matching entry pops, then a full `READ_LAT`.
- `wb_full` / `wb_empty` are registered and reflect the count after each edge.
- Reset asserted mid-burst or mid-read immediately drops `l2_ack` / `mem_wr_valid`. Partial bursts are discarded silently; `wb_err` is not set by reset.

## Structure
- `l2_pkg`: read FSM state encoding, `LINE_W`=27, line-offset constant 5.
- Sub-module `line_fifo`: parameterised depth/width, with push/pop/full/empty and per-entry valid plus line outputs for the hazard compare. The FSM, beat counter and hazard logic stay in `l2_responder`.

## Test plan
- Clean read, `READ_LAT`=4: `read_l2`=1 at edge 0, line 0x100 → `l2_ack` high only in cycle after edge 4. A held `read_l2` in the next cycle yields no second ack.
- Write burst: `write_l2` high 8 cycles, addr 0x0000_2040 → one entry with line 0x102. With `mem_wr_ready`=1 it pops one cycle after push.
- Hazard: buffer line 0x102 with `mem_wr_ready`=0, then read 0x0000_2040 → no ack. Raise ready at edge 10 → pop at edge 10, `l2_ack` 4 cycles after hazard clears.
- Overflow: 5 bursts with ready=0, depth 4 → `wb_full`=1, 5th entry dropped, `wb_err`=1. Then drain → exactly 4 pops.
- Short burst: `write_l2` high 3 cycles → no push, `wb_err`=1, `wb_empty`=1.
- Reset during R_WAIT and mid-burst → all outputs at reset values next cycle. A later read acks after exactly `READ_LAT`.
